// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback queue entry type.
// Used by the writeback queue and by the register-file address decode.
package cpu_pkg;

    localparam int DATA_W   = 12;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/reg_onehot_decoder.sv
// Register address to one-hot select decode, gated by an enable.
// Purely combinational, zero latency; no backpressure (select is all-zero when en=0).
// Out-of-range addresses (addr >= NUM_REGS) produce an all-zero select.
module reg_onehot_decoder #(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_REGS-1:0] sel
);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = en && (32'(addr) == i);
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO feeding the register cells; WBQ_FWD_EN adds a pending-write forward search.
// Latency: a push into an empty queue drives w_en the next cycle (no same-cycle bypass).
// Backpressure: in_ready low while full; stall holds the head entry without loss.
module reg_writeback_queue #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         stall,
    output logic [NUM_REGS-1:0]          chosen,
    output logic                         w_en,
    output logic [DATA_W-1:0]            w_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
`ifdef WBQ_FWD_EN
    input  logic [ADDR_W-1:0]            fwd_addr,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data,
`endif
    output logic                         err
);

    import cpu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wbq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             addr_ok;
    logic             push;
    logic             pop;
    wbq_entry_t       head_entry;

    assign addr_ok    = 32'(in_addr) < NUM_REGS;
    assign in_ready   = count != CNT_W'(DEPTH);
    assign empty      = count == '0;
    assign push       = in_valid && in_ready && addr_ok;
    // Reset suppresses the strobe so pending entries never reach the cells on the reset edge.
    assign w_en       = !empty && !stall && !rst;
    assign pop        = w_en;
    assign head_entry = mem[head];
    assign w_data     = head_entry.data;

    reg_onehot_decoder #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_dec (
        .addr (head_entry.addr),
        .en   (w_en),
        .sel  (chosen)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{addr: in_addr, data: in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Dropped requests (full or illegal register) latch the error until reset.
            if (in_valid && !(in_ready && addr_ok)) err <= 1'b1;
        end
    end

`ifdef WBQ_FWD_EN
    // Walk oldest to youngest so the last match left standing is the youngest write.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(count) && mem[PTR_W'(head + PTR_W'(k))].addr == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[PTR_W'(head + PTR_W'(k))].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed-vector bench for reg_writeback_queue: default instance plus a NUM_REGS=5 instance.
module tb_reg_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, stall, w_en, empty, err;
    logic [2:0]  in_addr;
    logic [11:0] in_data, w_data;
    logic [7:0]  chosen;
    logic [2:0]  count;

    logic        b_in_valid, b_in_ready, b_stall, b_w_en, b_empty, b_err;
    logic [2:0]  b_in_addr;
    logic [11:0] b_in_data, b_w_data;
    logic [4:0]  b_chosen;
    logic [2:0]  b_count;

`ifdef WBQ_FWD_EN
    logic [2:0]  fwd_addr, b_fwd_addr;
    logic        fwd_hit, b_fwd_hit;
    logic [11:0] fwd_data, b_fwd_data;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .stall(stall), .chosen(chosen),
        .w_en(w_en), .w_data(w_data), .count(count), .empty(empty),
`ifdef WBQ_FWD_EN
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
        .err(err)
    );

    reg_writeback_queue #(.NUM_REGS(5), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_addr(b_in_addr), .in_data(b_in_data), .stall(b_stall), .chosen(b_chosen),
        .w_en(b_w_en), .w_data(b_w_data), .count(b_count), .empty(b_empty),
`ifdef WBQ_FWD_EN
        .fwd_addr(b_fwd_addr), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data),
`endif
        .err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle 1ns past it before inputs change or outputs are read.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; stall = 1'b0;
        b_in_valid = 1'b0; b_in_addr = '0; b_in_data = '0; b_stall = 1'b0;
`ifdef WBQ_FWD_EN
        fwd_addr = '0; b_fwd_addr = '0;
`endif
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_w_en",     32'(w_en),     32'd0);
        chk("rst_chosen",   32'(chosen),   32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_err",      32'(err),      32'd0);

        // Single write: no bypass, then one cycle later on the cell port.
        in_valid = 1'b1; in_addr = 3'd2; in_data = 12'hABC;
        #1;
        chk("nobypass_w_en", 32'(w_en), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("single_w_en",   32'(w_en),   32'd1);
        chk("single_chosen", 32'(chosen), 32'h04);
        chk("single_w_data", 32'(w_data), 32'hABC);
        chk("single_count",  32'(count),  32'd1);
        tick();
        chk("single_empty",  32'(empty),  32'd1);
        chk("single_w_en0",  32'(w_en),   32'd0);

        // Fill under stall, overflow attempt, then ordered drain.
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_addr = 3'(i); in_data = 12'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("full_count",    32'(count),    32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_err0",     32'(err),      32'd0);
        chk("stall_w_en",    32'(w_en),     32'd0);
        in_valid = 1'b1; in_addr = 3'd5; in_data = 12'h005;
        tick();
        in_valid = 1'b0;
        #1;
        chk("ovf_err",   32'(err),   32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        stall = 1'b0;
        #1;
        chk("pop_full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain%0d_w_en", i),   32'(w_en),   32'd1);
            chk($sformatf("drain%0d_data", i),   32'(w_data), 32'(i));
            chk($sformatf("drain%0d_chosen", i), 32'(chosen), 32'(1 << i));
            tick();
            if (i == 1) chk("ready_after_pop", 32'(in_ready), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("err_sticky",  32'(err),   32'd1);

        // Reset clears the error before the streaming run.
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("rst2_err", 32'(err), 32'd0);

        // Continuous push+drain, ten entries across more than two pointer laps.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_addr = 3'(i % 8); in_data = 12'(32'h100 + i);
            #1;
            if (i > 0) begin
                chk($sformatf("stream%0d_data", i - 1),   32'(w_data), 32'h100 + 32'(i - 1));
                chk($sformatf("stream%0d_chosen", i - 1), 32'(chosen), 32'(1 << ((i - 1) % 8)));
                chk($sformatf("stream%0d_count", i - 1),  32'(count),  32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("stream9_data", 32'(w_data), 32'h109);
        chk("stream9_w_en", 32'(w_en),   32'd1);
        tick();
        chk("stream_empty", 32'(empty), 32'd1);

        // Reset mid-drain with three pending entries.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = 3'(i); in_data = 12'(32'h200 + i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1; stall = 1'b0;
        #1;
        chk("rst_cycle_w_en", 32'(w_en), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_w_en",  32'(w_en),  32'd0);
        chk("midrst_err",   32'(err),   32'd0);
        in_valid = 1'b1; in_addr = 3'd7; in_data = 12'h777;
        tick();
        in_valid = 1'b0;
        #1;
        chk("post_rst_w_en",   32'(w_en),   32'd1);
        chk("post_rst_chosen", 32'(chosen), 32'h80);
        chk("post_rst_data",   32'(w_data), 32'h777);
        tick();

        // Illegal register address on a five-register file.
        b_in_valid = 1'b1; b_in_addr = 3'd5; b_in_data = 12'h555;
        tick();
        b_in_valid = 1'b0;
        #1;
        chk("b_illegal_count", 32'(b_count), 32'd0);
        chk("b_illegal_empty", 32'(b_empty), 32'd1);
        chk("b_illegal_err",   32'(b_err),   32'd1);
        b_in_valid = 1'b1; b_in_addr = 3'd4; b_in_data = 12'h444;
        tick();
        b_in_valid = 1'b0;
        #1;
        chk("b_legal_w_en",   32'(b_w_en),   32'd1);
        chk("b_legal_chosen", 32'(b_chosen), 32'h10);
        chk("b_legal_data",   32'(b_w_data), 32'h444);
        tick(); tick();
        chk("b_err_sticky", 32'(b_err), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("b_err_cleared", 32'(b_err), 32'd0);

`ifdef WBQ_FWD_EN
        // Forwarding picks the youngest pending write to the same register.
        stall = 1'b1;
        in_valid = 1'b1; in_addr = 3'd3; in_data = 12'h111;
        tick();
        in_data = 12'h222;
        tick();
        in_valid = 1'b0;
        fwd_addr = 3'd3;
        #1;
        chk("fwd_hit",  32'(fwd_hit),  32'd1);
        chk("fwd_data", 32'(fwd_data), 32'h222);
        fwd_addr = 3'd6;
        #1;
        chk("fwd_miss_hit",  32'(fwd_hit),  32'd0);
        chk("fwd_miss_data", 32'(fwd_data), 32'd0);
        stall = 1'b0;
        fwd_addr = 3'd3;
        #1;
        chk("fwd_head_hit", 32'(fwd_hit), 32'd1);
        chk("same_reg_first", 32'(w_data), 32'h111);
        tick();
        chk("same_reg_second", 32'(w_data), 32'h222);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Writeback stage directly upstream of the register file's per-register 12-bit storage cells.
- Accepts (register address, data) write requests from execute via valid/ready.
- Buffers them in a small in-order FIFO and drains one per cycle as the one-hot chosen select, w_en and w_data that the register cells consume.
- Lets execute run ahead while the register file is stalled.

Parameters:
- DATA_W, 12, width of register data.
- NUM_REGS, 8, number of architectural registers; width of chosen.
- ADDR_W, 3, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute presents a write request.
- in_ready  out  1  queue can accept; high iff count < DEPTH.
- in_addr  in  ADDR_W  destination register.
- in_data  in  DATA_W  write data.
- stall  in  1  register file hold; blocks draining.
- chosen  out  NUM_REGS  one-hot register select for head entry.
- w_en  out  1  write strobe to register cells.
- w_data  out  DATA_W  head entry data.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst=1 at clock edge):
  - head/tail pointers 0, count 0, err 0.
  - Outputs: w_en 0, chosen 0, empty 1, in_ready 1.
  - Entry storage is not cleared.
  - Reset mid-drain discards all pending entries; no write is issued in the reset cycle.
- Push:
  - in_valid & in_ready & (in_addr < NUM_REGS) at an edge stores {in_addr, in_data} at tail; tail increments mod DEPTH.
- Drain is combinational from state:
  - w_en = !empty & !stall.
  - chosen = one-hot(head.addr) when w_en, else all zeros.
  - w_data = head.data (don't-care when w_en=0; drive head entry anyway).
- Pop: w_en high at an edge advances head mod DEPTH.
- Latency: request pushed into an empty queue drives w_en in the next cycle. No same-cycle bypass from in_* to w_*.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Full (count == DEPTH):
  - in_ready = 0.
  - A pop in the same cycle does not raise in_ready combinationally; it rises the following cycle.
- Ordering:
  - Strict FIFO.
  - Two pending writes to the same register both drain, in order; the last one wins in the register.
- Pointer wrap-around must be exercised: DEPTH pushes/pops beyond the first lap keep data intact.
- err set (sticky until rst) when either:
  - in_valid & !in_ready (overflow attempt; request dropped), or
  - in_valid & in_ready & in_addr >= NUM_REGS (illegal address; request dropped, no push).
- stall held high: queue fills to DEPTH and holds; no entries lost; draining resumes on the first cycle stall=0.

Optional Feature:
- Macro: WBQ_FWD_EN.
- Enabled, adds ports:
  - fwd_addr in ADDR_W.
  - fwd_hit out 1.
  - fwd_data out DATA_W.
- Forwarding behaviour:
  - Combinational search of valid pending entries, including the head being drained this cycle.
  - fwd_hit=1 and fwd_data = data of the youngest entry whose addr == fwd_addr.
  - Otherwise fwd_hit=0 and fwd_data=0.
  - Requests being pushed this cycle are not searched.
- Disabled: ports absent; no comparators synthesised.

Decomposition:
- Shared package cpu_pkg:
  - constants DATA_W=12, NUM_REGS, ADDR_W.
  - typedef wbq_entry_t {addr[ADDR_W], data[DATA_W]}.
- Sub-module reg_onehot_decoder(addr, en -> sel[NUM_REGS]). The register-file address decode reuses it.

Test Plan:
- Reset, then push addr=2 data=0xABC with stall=0 -> next cycle w_en=1, chosen=8'b0000_0100, w_data=0xABC; following cycle empty=1, w_en=0.
- stall=1, push 4 entries (addr 1..4, data 0x001..0x004) -> count=4, in_ready=0. Fifth push -> err=1, entry dropped. Release stall -> four writes in order 1..4 on consecutive cycles.
- Continuous push+drain for 10 entries (data 0x100+i, addr i%8) -> count stays 1, every value appears on w_data in order, pointers wrap twice.
- Push in_addr=5 with NUM_REGS=5 -> no push, count unchanged, err=1 and stays 1 until rst.
- Fill to 3 entries, assert rst for one cycle -> count=0, empty=1, w_en=0, err=0; a new push afterwards drains normally.
- With WBQ_FWD_EN and stall=1:
  - push (3,0x111) then (3,0x222) with fwd_addr=3 -> fwd_hit=1, fwd_data=0x222.
  - fwd_addr=6 -> fwd_hit=0, fwd_data=0.
